// File: rtl/wb_pkg.sv
// Shared types for the merge wait buffer: mode FSM encoding, entry layout and byte-merge helper.
// Entry field widths are fixed here; the top's width parameters default to these values.
package wb_pkg;

   localparam int WB_ADDR_BITS  = 32;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_TAG_WIDTH  = 3;
   localparam int WB_BE_W       = WB_DATA_WIDTH / 8;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } wb_mode_e;

   typedef struct packed {
      logic [WB_ADDR_BITS-1:0]  addr;
      logic [WB_DATA_WIDTH-1:0] data;
      logic [WB_BE_W-1:0]       be;
      logic [WB_TAG_WIDTH-1:0]  tag;
   } wb_entry_t;

   // Bytes of new_d whose enable is set replace the matching bytes of old_d.
   function automatic logic [WB_DATA_WIDTH-1:0] merge_bytes(
      input logic [WB_DATA_WIDTH-1:0] old_d,
      input logic [WB_DATA_WIDTH-1:0] new_d,
      input logic [WB_BE_W-1:0]       be
   );
      logic [WB_DATA_WIDTH-1:0] res;
      res = old_d;
      for (int b = 0; b < WB_BE_W; b++) begin
         if (be[b]) res[8*b +: 8] = new_d[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/merge_wait_buffer_select.sv
// Per-lane age-ordered pick: returns the byte from the youngest slot whose hit bit is set,
// where slot tail-1 is youngest and age increases walking back toward tail.
module youngest_byte_select #(
   parameter int  DEPTH = 8,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]      hit,
   input  logic [DEPTH-1:0][7:0] lane_bytes,
   input  logic [PW-1:0]         tail,
   output logic                  found,
   output logic [7:0]            sel_byte
);

   logic [PW-1:0] slot;

   always_comb begin
      found    = 1'b0;
      sel_byte = 8'h00;
      slot     = '0;
      // oldest first, so a younger hit overwrites an older one
      for (int k = DEPTH; k >= 1; k--) begin
         slot = tail - PW'(k);
         if (hit[slot]) begin
            found    = 1'b1;
            sel_byte = lane_bytes[slot];
         end
      end
   end

endmodule

// File: rtl/merge_wait_buffer.sv
// Store wait buffer: circular FIFO draining to the cache, merging same-word stores into the
// youngest entry, and forwarding bytes to loads from the youngest matching entry per lane.
module merge_wait_buffer
   import wb_pkg::*;
#(
   parameter int  DATA_WIDTH   = WB_DATA_WIDTH,
   parameter int  ADDR_BITS    = WB_ADDR_BITS,
   parameter int  DEPTH        = 8,
   parameter int  SEARCH_PORTS = 2,
   parameter int  TAG_WIDTH    = WB_TAG_WIDTH,
   localparam int BE_W         = DATA_WIDTH / 8,
   localparam int OFS          = $clog2(BE_W),
   localparam int PW           = $clog2(DEPTH),
   localparam int CW           = $clog2(DEPTH) + 1
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    wr_valid,
   output logic                                    wr_ready,
   input  logic [ADDR_BITS-1:0]                    wr_addr,
   input  logic [DATA_WIDTH-1:0]                   wr_data,
   input  logic [BE_W-1:0]                         wr_be,
   input  logic [TAG_WIDTH-1:0]                    wr_tag,
   input  logic [SEARCH_PORTS-1:0][ADDR_BITS-1:0]  srch_addr,
   input  logic [SEARCH_PORTS-1:0][BE_W-1:0]       srch_be,
   output logic [SEARCH_PORTS-1:0][DATA_WIDTH-1:0] fwd_data,
   output logic [SEARCH_PORTS-1:0][BE_W-1:0]       fwd_be,
   output logic [SEARCH_PORTS-1:0]                 fwd_full,
   output logic [SEARCH_PORTS-1:0]                 fwd_partial,
   output logic                                    dr_valid,
   input  logic                                    dr_ready,
   output logic [ADDR_BITS-1:0]                    dr_addr,
   output logic [DATA_WIDTH-1:0]                   dr_data,
   output logic [BE_W-1:0]                         dr_be,
   output logic [TAG_WIDTH-1:0]                    dr_tag,
   input  logic                                    flush_req,
   output logic                                    flush_done,
   output logic [CW-1:0]                           count
);

   wb_entry_t        ent [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    head, tail, youngest;
   logic [CW-1:0]    cnt;
   wb_mode_e         mode, mode_nxt;
   logic             wr_fire, do_merge, do_alloc, do_pop;

   assign youngest = tail - PW'(1);
   assign wr_ready = (cnt != CW'(DEPTH)) && (mode == RUN);
   assign wr_fire  = wr_valid && wr_ready;
   // count >= 2 keeps the merge target away from a head entry that may pop this cycle
   assign do_merge = wr_fire && (cnt >= CW'(2)) &&
                     (ent[youngest].addr[ADDR_BITS-1:OFS] == wr_addr[ADDR_BITS-1:OFS]);
   assign do_alloc = wr_fire && !do_merge;
   assign dr_valid = (cnt != '0);
   assign do_pop   = dr_valid && dr_ready;
   assign count    = cnt;

   assign dr_addr  = ent[head].addr;
   assign dr_data  = ent[head].data;
   assign dr_be    = ent[head].be;
   assign dr_tag   = ent[head].tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         vld  <= '0;
         mode <= RUN;
      end else begin
         mode <= mode_nxt;
         cnt  <= cnt + CW'(do_alloc) - CW'(do_pop);
         if (do_pop) begin
            vld[head] <= 1'b0;
            head      <= head + PW'(1);
         end
         if (do_alloc) begin
            vld[tail] <= 1'b1;
            tail      <= tail + PW'(1);
         end
      end
   end

   // Payload storage carries no reset; validity lives in vld.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         ent[tail] <= '{addr: wr_addr, data: wr_data, be: wr_be, tag: wr_tag};
      end else if (do_merge) begin
         ent[youngest].data <= merge_bytes(ent[youngest].data, wr_data, wr_be);
         ent[youngest].be   <= ent[youngest].be | wr_be;
         ent[youngest].tag  <= wr_tag;
      end
   end

   always_comb begin
      mode_nxt   = mode;
      flush_done = 1'b0;
      case (mode)
         RUN: begin
            if (flush_req) mode_nxt = FLUSH;
         end
         FLUSH: begin
            if (cnt == '0) begin
               mode_nxt   = RUN;
               flush_done = 1'b1;
            end
         end
         default: mode_nxt = RUN;
      endcase
   end

   for (genvar p = 0; p < SEARCH_PORTS; p++) begin : g_port
      logic [DEPTH-1:0] addr_hit;

      if (OFS > 0) begin : g_lo
         logic lo_unused;
         assign lo_unused = ^srch_addr[p][OFS-1:0];
      end

      for (genvar e = 0; e < DEPTH; e++) begin : g_ent
         assign addr_hit[e] = vld[e] &&
                              (ent[e].addr[ADDR_BITS-1:OFS] == srch_addr[p][ADDR_BITS-1:OFS]);
      end

      for (genvar b = 0; b < BE_W; b++) begin : g_lane
         logic [DEPTH-1:0]      hit;
         logic [DEPTH-1:0][7:0] lane_bytes;
         logic                  found;
         logic [7:0]            sel_byte;

         for (genvar e = 0; e < DEPTH; e++) begin : g_e
            assign hit[e]        = addr_hit[e] && ent[e].be[b];
            assign lane_bytes[e] = ent[e].data[8*b +: 8];
         end

         youngest_byte_select #(.DEPTH(DEPTH)) u_sel (
            .hit        (hit),
            .lane_bytes (lane_bytes),
            .tail       (tail),
            .found      (found),
            .sel_byte   (sel_byte)
         );

         assign fwd_be[p][b]         = found && srch_be[p][b];
         assign fwd_data[p][8*b +: 8] = fwd_be[p][b] ? sel_byte : 8'h00;
      end

      assign fwd_full[p]    = (|fwd_be[p]) && ((srch_be[p] & ~fwd_be[p]) == '0);
      assign fwd_partial[p] = (|(srch_be[p] & fwd_be[p])) && !fwd_full[p];
   end

endmodule

// File: tb/tb_merge_wait_buffer.sv
// Bench for merge_wait_buffer: directed vector table, multi-cycle corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_merge_wait_buffer;
   import wb_pkg::*;

   localparam int DW = 32, AW = 32, DEPTH = 8, NP = 2, TW = 3, BW = 4, CW = 4;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b1;
   logic                   wr_valid, wr_ready;
   logic [AW-1:0]          wr_addr;
   logic [DW-1:0]          wr_data;
   logic [BW-1:0]          wr_be;
   logic [TW-1:0]          wr_tag;
   logic [NP-1:0][AW-1:0]  srch_addr;
   logic [NP-1:0][BW-1:0]  srch_be;
   logic [NP-1:0][DW-1:0]  fwd_data;
   logic [NP-1:0][BW-1:0]  fwd_be;
   logic [NP-1:0]          fwd_full, fwd_partial;
   logic                   dr_valid, dr_ready;
   logic [AW-1:0]          dr_addr;
   logic [DW-1:0]          dr_data;
   logic [BW-1:0]          dr_be;
   logic [TW-1:0]          dr_tag;
   logic                   flush_req, flush_done;
   logic [CW-1:0]          count;

   always #5 clk = ~clk;

   merge_wait_buffer #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .DEPTH(DEPTH),
                       .SEARCH_PORTS(NP), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .wr_tag(wr_tag),
      .srch_addr(srch_addr), .srch_be(srch_be), .fwd_data(fwd_data), .fwd_be(fwd_be),
      .fwd_full(fwd_full), .fwd_partial(fwd_partial),
      .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_addr(dr_addr), .dr_data(dr_data),
      .dr_be(dr_be), .dr_tag(dr_tag),
      .flush_req(flush_req), .flush_done(flush_done), .count(count)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
      logic [TW-1:0] tag;
   } m_ent_t;

   typedef struct {
      logic          wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [BW-1:0] wbe;
      logic [TW-1:0] wt;
      logic [AW-1:0] sa;
      logic [BW-1:0] sbe;
      logic [CW-1:0] ecount;
      logic          erdy, efull, epart;
      logic [BW-1:0] ebe;
      logic [DW-1:0] edata;
   } vec_t;

   m_ent_t        mq[$];
   bit            m_flush;
   int            checks = 0, failures = 0;
   vec_t          tbl [8];
   logic [AW-1:0] last_a;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit same_word(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return (a >> 2) == (b >> 2);
   endfunction

   // Per requested lane, scan from youngest to oldest for an entry holding that byte.
   task automatic m_search(input logic [AW-1:0] a, input logic [BW-1:0] need,
                           output logic [DW-1:0] d, output logic [BW-1:0] be,
                           output logic full, output logic partial);
      d  = '0;
      be = '0;
      for (int b = 0; b < BW; b++) begin
         if (need[b]) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
               if (same_word(mq[i].addr, a) && mq[i].be[b]) begin
                  be[b] = 1'b1;
                  d[8*b +: 8] = mq[i].data[8*b +: 8];
                  break;
               end
            end
         end
      end
      full    = (be != 0) && ((need & ~be) == 0);
      partial = ((need & be) != 0) && !full;
   endtask

   task automatic check_all(input string tag);
      logic [DW-1:0] d;
      logic [BW-1:0] be;
      logic          f, pa;
      chk({tag, ".wr_ready"}, wr_ready, (mq.size() != DEPTH) && !m_flush);
      chk({tag, ".count"}, count, mq.size());
      chk({tag, ".dr_valid"}, dr_valid, mq.size() != 0);
      chk({tag, ".flush_done"}, flush_done, m_flush && mq.size() == 0);
      if (mq.size() != 0) begin
         chk({tag, ".dr_addr"}, dr_addr, mq[0].addr);
         chk({tag, ".dr_data"}, dr_data, mq[0].data);
         chk({tag, ".dr_be"}, dr_be, mq[0].be);
         chk({tag, ".dr_tag"}, dr_tag, mq[0].tag);
      end
      for (int p = 0; p < NP; p++) begin
         m_search(srch_addr[p], srch_be[p], d, be, f, pa);
         chk($sformatf("%s.fwd_data%0d", tag, p), fwd_data[p], d);
         chk($sformatf("%s.fwd_be%0d", tag, p), fwd_be[p], be);
         chk($sformatf("%s.fwd_full%0d", tag, p), fwd_full[p], f);
         chk($sformatf("%s.fwd_partial%0d", tag, p), fwd_partial[p], pa);
      end
   endtask

   task automatic m_step;
      m_ent_t e;
      bit     rdy, fire, pop, fd;
      rdy  = (mq.size() != DEPTH) && !m_flush;
      fire = wr_valid && rdy;
      pop  = (mq.size() != 0) && dr_ready;
      fd   = m_flush && (mq.size() == 0);
      if (fire && mq.size() >= 2 && same_word(mq[mq.size()-1].addr, wr_addr)) begin
         e = mq[mq.size()-1];
         for (int b = 0; b < BW; b++)
            if (wr_be[b]) e.data[8*b +: 8] = wr_data[8*b +: 8];
         e.be  = e.be | wr_be;
         e.tag = wr_tag;
         mq[mq.size()-1] = e;
      end else if (fire) begin
         e.addr = wr_addr; e.data = wr_data; e.be = wr_be; e.tag = wr_tag;
         mq.push_back(e);
      end
      if (pop) void'(mq.pop_front());
      if (!m_flush && flush_req) m_flush = 1'b1;
      else if (fd) m_flush = 1'b0;
   endtask

   // Called one time unit after a rising edge with inputs already driven.
   task automatic step(input string tag);
      #1;
      check_all(tag);
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      wr_valid = 0; wr_addr = '0; wr_data = '0; wr_be = '0; wr_tag = '0;
      dr_ready = 0; flush_req = 0;
      for (int p = 0; p < NP; p++) begin
         srch_addr[p] = 32'h100;
         srch_be[p]   = 4'hF;
      end
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      mq.delete();
      m_flush = 1'b0;
      #2;
      check_all("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be,
                     input logic [TW-1:0] t);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be; wr_tag = t;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      bit seen;

      // wv  wa          wd            wbe  wt  sa          sbe   cnt rdy full part ebe  edata
      tbl[0] = '{1, 32'h200, 32'h00005566, 4'h3, 3'd1, 32'h200, 4'h3, 4'd0, 1, 0, 0, 4'h0, 32'h0};
      tbl[1] = '{1, 32'h204, 32'h99887766, 4'hF, 3'd2, 32'h200, 4'h3, 4'd1, 1, 1, 0, 4'h3, 32'h00005566};
      tbl[2] = '{1, 32'h204, 32'h11220000, 4'hC, 3'd3, 32'h204, 4'hF, 4'd2, 1, 1, 0, 4'hF, 32'h99887766};
      tbl[3] = '{0, 32'h0,   32'h0,        4'h0, 3'd0, 32'h204, 4'hF, 4'd2, 1, 1, 0, 4'hF, 32'h11227766};
      tbl[4] = '{1, 32'h100, 32'hAABBCCDD, 4'hF, 3'd4, 32'h204, 4'hC, 4'd2, 1, 1, 0, 4'hC, 32'h11220000};
      tbl[5] = '{1, 32'h300, 32'h000000EE, 4'h1, 3'd5, 32'h100, 4'hF, 4'd3, 1, 1, 0, 4'hF, 32'hAABBCCDD};
      tbl[6] = '{0, 32'h0,   32'h0,        4'h0, 3'd0, 32'h300, 4'h3, 4'd4, 1, 0, 1, 4'h1, 32'h000000EE};
      tbl[7] = '{0, 32'h0,   32'h0,        4'h0, 3'd0, 32'h400, 4'hF, 4'd4, 1, 0, 0, 4'h0, 32'h0};

      do_reset();
      srch_addr[1] = 32'h204;
      srch_be[1]   = 4'hF;
      for (int i = 0; i < 8; i++) begin
         wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
         wr_be = tbl[i].wbe; wr_tag = tbl[i].wt;
         srch_addr[0] = tbl[i].sa; srch_be[0] = tbl[i].sbe;
         #1;
         chk($sformatf("vec%0d.count", i), count, tbl[i].ecount);
         chk($sformatf("vec%0d.wr_ready", i), wr_ready, tbl[i].erdy);
         chk($sformatf("vec%0d.fwd_full", i), fwd_full[0], tbl[i].efull);
         chk($sformatf("vec%0d.fwd_partial", i), fwd_partial[0], tbl[i].epart);
         chk($sformatf("vec%0d.fwd_be", i), fwd_be[0], tbl[i].ebe);
         chk($sformatf("vec%0d.fwd_data", i), fwd_data[0], tbl[i].edata);
         step($sformatf("vec%0d", i));
      end
      // Merged entry should drain second with full enables and the new upper bytes.
      wr_valid = 0;
      dr_ready = 1;
      step("pop_first");
      dr_ready = 0;
      #1;
      chk("merge.dr_addr", dr_addr, 32'h204);
      chk("merge.dr_be", dr_be, 4'hF);
      chk("merge.dr_hi", dr_data[31:16], 16'h1122);
      chk("merge.dr_tag", dr_tag, 3'd3);
      step("merge_view");

      // Full buffer: pop with a same-cycle write does not accept the write.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         wr(32'h1000 + 32'(i * 16), $urandom, 4'hF, 3'(i));
         step("fill");
      end
      wr_valid = 0;
      #1;
      chk("full.wr_ready", wr_ready, 1'b0);
      chk("full.count", count, 4'd8);
      wr(32'h2000, 32'h12345678, 4'hF, 3'd7);
      dr_ready = 1;
      #1;
      chk("full.pop_wr_ready", wr_ready, 1'b0);
      step("full_pop");
      wr_valid = 0;
      dr_ready = 0;
      #1;
      chk("full.after_count", count, 4'd7);
      chk("full.after_wr_ready", wr_ready, 1'b1);
      step("full_after");

      // Flush of three entries.
      do_reset();
      wr(32'h040, 32'h01020304, 4'hF, 3'd1); step("fl_w0");
      wr(32'h080, 32'h05060708, 4'hF, 3'd2); step("fl_w1");
      wr(32'h0C0, 32'h090A0B0C, 4'hF, 3'd3); step("fl_w2");
      wr_valid = 0;
      flush_req = 1;
      step("fl_req");
      flush_req = 0;
      dr_ready = 1;
      gap = 0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         #1;
         if (flush_done) begin
            seen = 1;
            chk("flush.count_at_done", count, 4'd0);
         end else if (!wr_ready) begin
            gap++;
         end
         step("flush");
      end
      chk("flush.done_seen", seen, 1'b1);
      chk("flush.blocked_cycles", gap, 3);
      #1;
      chk("flush.after_wr_ready", wr_ready, 1'b1);
      chk("flush.after_done", flush_done, 1'b0);
      dr_ready = 0;
      step("flush_after");

      // Flush with an empty buffer.
      do_reset();
      flush_req = 1;
      step("efl_req");
      flush_req = 0;
      #1;
      chk("eflush.done", flush_done, 1'b1);
      chk("eflush.wr_ready", wr_ready, 1'b0);
      step("efl_done");
      #1;
      chk("eflush.done_clear", flush_done, 1'b0);
      chk("eflush.wr_ready_back", wr_ready, 1'b1);
      step("efl_after");

      // Asynchronous reset in the middle of a flush drain.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wr(32'h500 + 32'(i * 8), $urandom, 4'hF, 3'(i));
         step("mr_fill");
      end
      wr_valid = 0;
      flush_req = 1;
      step("mr_flreq");
      flush_req = 0;
      dr_ready = 1;
      step("mr_drain");
      #2;
      rst_n = 1'b0;
      mq.delete();
      m_flush = 1'b0;
      #1;
      chk("midrst.count", count, 4'd0);
      chk("midrst.dr_valid", dr_valid, 1'b0);
      chk("midrst.flush_done", flush_done, 1'b0);
      chk("midrst.wr_ready", wr_ready, 1'b1);
      @(posedge clk); #1;
      dr_ready = 0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) step("midrst_after");

      // Randomized traffic against the model.
      do_reset();
      last_a = 32'h800;
      for (int c = 0; c < 3000; c++) begin
         wr_valid = ($urandom_range(0, 99) < 60);
         wr_addr  = ($urandom_range(0, 1) == 1) ? last_a : 32'h800 + 32'($urandom_range(0, 31));
         last_a   = wr_addr;
         wr_data  = $urandom;
         wr_be    = 4'($urandom_range(1, 15));
         wr_tag   = 3'($urandom);
         dr_ready = ($urandom_range(0, 99) < 40);
         flush_req = ($urandom_range(0, 99) < 2);
         for (int p = 0; p < NP; p++) begin
            srch_addr[p] = 32'h800 + 32'($urandom_range(0, 31));
            srch_be[p]   = 4'($urandom_range(1, 15));
         end
         step("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
